clock_set_ctrl: RTL and testbench

//  Time-setting controller for the digital clock (sits beside top_clock counters).

---
 rtl/clock_set_ctrl_pkg.sv | 17 +
 rtl/clock_set_ctrl_btn_edge_sync.sv | 31 +++
 rtl/clock_set_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared state codes and widths for the clock time-setting controller,
// also used by the display mux and the clock top level.
package clock_set_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  function automatic logic is_set_state(input state_e s);
    return s != ST_RUN;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_edge_sync.sv
// Two-flop synchroniser for a debounced push-button plus rising-edge detect.
// A press sampled at edge k shows rise_o between edges k+1 and k+2.
module clock_set_ctrl_btn_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // prev_q clears on reset, so a button held through reset reads as a new press
  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: MODE/INC button FSM that gates seconds counting and
// issues increment/clear pulses and digit-blink enables to the BCD time counters.
//
//   state       | meaning
//   ST_RUN      | normal timekeeping, seconds advance, INC ignored
//   ST_SET_HOUR | hour digits blink, INC (and auto-repeat) bumps hours
//   ST_SET_MIN  | minute digits blink, INC (and auto-repeat) bumps minutes
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned REPEAT_DLY    = 50,
  parameter int unsigned REPEAT_PER    = 10,
  parameter int unsigned TIMEOUT_TICKS = 3000,
  parameter int unsigned BLINK_HALF    = 50
) (
  input  logic              inclk_i,
  input  logic              rst_i,
  input  logic              tick_100hz_i,
  input  logic              btn_mode_i,
  input  logic              btn_inc_i,
  output logic              run_en_o,
  output logic              inc_hour_o,
  output logic              inc_min_o,
  output logic              clr_sec_o,
  output logic              blink_hour_o,
  output logic              blink_min_o,
  output logic [MODE_W-1:0] mode_o
);

  localparam int unsigned REP_W = $clog2(REPEAT_DLY + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned BL_W  = $clog2(BLINK_HALF + 1);

  localparam logic [REP_W-1:0] REP_TC     = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DLY - REPEAT_PER);
  localparam logic [TO_W-1:0]  TO_TC      = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [BL_W-1:0]  BL_TC      = BL_W'(BLINK_HALF - 1);

  state_e state_q, state_d;

  logic mode_rise, mode_level_unused;
  logic inc_rise, inc_level;
  logic in_set, state_chg, btn_evt, rep_fire, to_hit;

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [BL_W-1:0]  bl_cnt_q, bl_cnt_d;
  logic             phase_q, phase_d;

  logic run_en_q, run_en_d;
  logic inc_hour_q, inc_hour_d;
  logic inc_min_q, inc_min_d;
  logic clr_sec_q, clr_sec_d;
  logic blink_hour_q, blink_hour_d;
  logic blink_min_q, blink_min_d;

  clock_set_ctrl_btn_edge_sync u_sync_mode (
    .clk_i   (inclk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_mode_i),
    .level_o (mode_level_unused),
    .rise_o  (mode_rise)
  );

  clock_set_ctrl_btn_edge_sync u_sync_inc (
    .clk_i   (inclk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_inc_i),
    .level_o (inc_level),
    .rise_o  (inc_rise)
  );

  assign in_set   = is_set_state(state_q);
  assign btn_evt  = mode_rise | inc_rise;
  // MODE edge wins over any INC activity in the same cycle
  assign rep_fire = in_set & inc_level & tick_100hz_i & ~mode_rise & (rep_cnt_q == REP_TC);
  assign to_hit   = in_set & tick_100hz_i & ~btn_evt & ~rep_fire & (to_cnt_q == TO_TC);

  always_ff @(posedge inclk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mode_rise) state_d = ST_SET_HOUR;
      ST_SET_HOUR: begin
        if (mode_rise)   state_d = ST_SET_MIN;
        else if (to_hit) state_d = ST_RUN;
      end
      ST_SET_MIN:  if (mode_rise || to_hit) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    run_en_d   = (state_d == ST_RUN);
    inc_hour_d = (state_q == ST_SET_HOUR) & ~mode_rise & (inc_rise | rep_fire);
    inc_min_d  = (state_q == ST_SET_MIN)  & ~mode_rise & (inc_rise | rep_fire);
    // only a MODE-driven exit restarts the seconds; a timeout leaves them alone
    clr_sec_d  = (state_q == ST_SET_MIN)  & mode_rise;

    rep_cnt_d = rep_cnt_q;
    if (!in_set || !inc_level || mode_rise || state_chg) rep_cnt_d = '0;
    else if (rep_fire)                                   rep_cnt_d = REP_RELOAD;
    else if (tick_100hz_i)                               rep_cnt_d = rep_cnt_q + 1'b1;

    to_cnt_d = to_cnt_q;
    if (!in_set || state_chg || btn_evt || rep_fire) to_cnt_d = '0;
    else if (tick_100hz_i)                           to_cnt_d = to_cnt_q + 1'b1;

    bl_cnt_d = bl_cnt_q;
    phase_d  = phase_q;
    if (!in_set || state_chg || inc_hour_d || inc_min_d) begin
      bl_cnt_d = '0;
      phase_d  = 1'b0;
    end else if (tick_100hz_i) begin
      if (bl_cnt_q == BL_TC) begin
        bl_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
      end
    end

    blink_hour_d = (state_d == ST_SET_HOUR) & phase_d;
    blink_min_d  = (state_d == ST_SET_MIN)  & phase_d;
  end

  always_ff @(posedge inclk_i) begin
    if (rst_i) begin
      rep_cnt_q    <= '0;
      to_cnt_q     <= '0;
      bl_cnt_q     <= '0;
      phase_q      <= 1'b0;
      run_en_q     <= 1'b1;
      inc_hour_q   <= 1'b0;
      inc_min_q    <= 1'b0;
      clr_sec_q    <= 1'b0;
      blink_hour_q <= 1'b0;
      blink_min_q  <= 1'b0;
    end else begin
      rep_cnt_q    <= rep_cnt_d;
      to_cnt_q     <= to_cnt_d;
      bl_cnt_q     <= bl_cnt_d;
      phase_q      <= phase_d;
      run_en_q     <= run_en_d;
      inc_hour_q   <= inc_hour_d;
      inc_min_q    <= inc_min_d;
      clr_sec_q    <= clr_sec_d;
      blink_hour_q <= blink_hour_d;
      blink_min_q  <= blink_min_d;
    end
  end

  assign run_en_o     = run_en_q;
  assign inc_hour_o   = inc_hour_q;
  assign inc_min_o    = inc_min_q;
  assign clr_sec_o    = clr_sec_q;
  assign blink_hour_o = blink_hour_q;
  assign blink_min_o  = blink_min_q;
  assign mode_o       = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus a random phase, all
// compared against a cycle-level reference built from tick/hold arithmetic.
module tb_clock_set_ctrl;

  localparam int REPEAT_DLY    = 5;
  localparam int REPEAT_PER    = 2;
  localparam int TIMEOUT_TICKS = 20;
  localparam int BLINK_HALF    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       run_en, inc_hour, inc_min, clr_sec, blink_hour, blink_min;
  logic [1:0] mode;
  logic [7:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit auto_tick = 1'b0;
  int tick_target = 0;
  int tick_sent   = 0;
  int cnt_h = 0, cnt_m = 0, cnt_c = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .REPEAT_DLY    (REPEAT_DLY),
    .REPEAT_PER    (REPEAT_PER),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .BLINK_HALF    (BLINK_HALF)
  ) dut (
    .inclk_i      (clk),
    .rst_i        (rst),
    .tick_100hz_i (tick),
    .btn_mode_i   (btn_mode),
    .btn_inc_i    (btn_inc),
    .run_en_o     (run_en),
    .inc_hour_o   (inc_hour),
    .inc_min_o    (inc_min),
    .clr_sec_o    (clr_sec),
    .blink_hour_o (blink_hour),
    .blink_min_o  (blink_min),
    .mode_o       (mode)
  );

  assign obs = {run_en, mode, inc_hour, inc_min, clr_sec, blink_hour, blink_min};

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  // Reference model: button delay lines, then counts of ticks since hold start,
  // since last activity and since last blink restart.
  logic [2:0] mh, ih;
  int         m_state, hold_n, idle_n, blink_n;
  logic [7:0] exp_out;

  always @(posedge clk) begin
    bit mr, ir, il, set, fire, hit, ph, eh, em, ec;
    int nxt;
    if (rst) begin
      mh = '0; ih = '0;
      m_state = 0; hold_n = 0; idle_n = 0; blink_n = 0;
      exp_out = 8'b1000_0000;
    end else begin
      mr  = mh[1] & ~mh[2];
      ir  = ih[1] & ~ih[2];
      il  = ih[1];
      set = (m_state != 0);
      fire = set && il && !mr && tick && (hold_n + 1 >= REPEAT_DLY) &&
             (((hold_n + 1 - REPEAT_DLY) % REPEAT_PER) == 0);
      hit = set && tick && !mr && !ir && !fire && (idle_n + 1 == TIMEOUT_TICKS);
      nxt = mr ? (m_state + 1) % 3 : (hit ? 0 : m_state);
      eh  = (m_state == 1) && !mr && (ir || fire);
      em  = (m_state == 2) && !mr && (ir || fire);
      ec  = (m_state == 2) && mr;
      if (!set || !il || mr || nxt != m_state) hold_n = 0;
      else if (tick) hold_n++;
      if (!set || nxt != m_state || mr || ir || fire) idle_n = 0;
      else if (tick) idle_n++;
      if (!set || nxt != m_state || eh || em) blink_n = 0;
      else if (tick) blink_n++;
      ph = ((blink_n / BLINK_HALF) % 2) == 1;
      m_state = nxt;
      exp_out = {nxt == 0, 2'(nxt), eh, em, ec, (nxt == 1) && ph, (nxt == 2) && ph};
      mh = {mh[1], mh[0], btn_mode};
      ih = {ih[1], ih[0], btn_inc};
    end
  end

  always @(negedge clk) begin
    if (inc_hour === 1'b1) cnt_h++;
    if (inc_min === 1'b1)  cnt_m++;
    if (clr_sec === 1'b1)  cnt_c++;
    if (chk_en) chk("outs", int'(obs), int'(exp_out));
  end

  initial begin : tick_gen
    int gap;
    gap  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = 1'b0;
      if (gap > 0) gap--;
      else if (tick_sent < tick_target) begin
        tick = 1'b1; tick_sent++; gap = 2;
      end else if (auto_tick && $urandom_range(0, 2) == 0) begin
        tick = 1'b1; gap = 1;
      end
    end
  end

  task automatic issue_ticks(input int n);
    int waited;
    tick_target = tick_target + n;
    waited = 0;
    while (tick_sent < tick_target && waited < n * 8 + 20) begin
      @(negedge clk);
      waited++;
    end
    chk("tick_wait", int'(tick_sent >= tick_target), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int h0, m0, c0;
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_mode", int'(mode), 0);
    chk("rst_pulses", int'({inc_hour, inc_min, clr_sec, blink_hour, blink_min}), 0);
    rst = 1'b0;

    h0 = cnt_h; m0 = cnt_m;
    btn_inc = 1'b1;
    repeat (6) @(negedge clk);
    btn_inc = 1'b0;
    repeat (4) @(negedge clk);
    chk("run_inc_ignored", (cnt_h - h0) + (cnt_m - m0), 0);

    press_mode();
    chk("mode_hour", int'(mode), 1);
    chk("run_en_set", int'(run_en), 0);
    press_mode();
    chk("mode_min", int'(mode), 2);
    c0 = cnt_c;
    press_mode();
    chk("mode_run", int'(mode), 0);
    chk("clr_sec_once", cnt_c - c0, 1);
    chk("run_en_back", int'(run_en), 1);

    press_mode();
    h0 = cnt_h;
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    chk("tap_lat1", int'(inc_hour), 0);
    @(negedge clk);
    chk("tap_lat2", int'(inc_hour), 0);
    @(negedge clk);
    chk("tap_hit", int'(inc_hour), 1);
    @(negedge clk);
    chk("tap_width", int'(inc_hour), 0);
    repeat (3) @(negedge clk);
    chk("tap_count", cnt_h - h0, 1);

    for (int t = 1; t < TIMEOUT_TICKS; t++) begin
      issue_ticks(1);
      chk("blink_hour", int'(blink_hour), (t / BLINK_HALF) % 2);
    end
    chk("to_not_yet", int'(mode), 1);
    c0 = cnt_c;
    issue_ticks(1);
    chk("to_mode", int'(mode), 0);
    chk("to_no_clr", cnt_c - c0, 0);

    press_mode();
    press_mode();
    m0 = cnt_m;
    btn_inc = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_edge", cnt_m - m0, 1);
    m0 = cnt_m;
    issue_ticks(11);
    chk("hold_repeat", cnt_m - m0, 4);
    btn_inc = 1'b0;
    repeat (4) @(negedge clk);
    m0 = cnt_m;
    issue_ticks(6);
    chk("release_none", cnt_m - m0, 0);
    chk("hold_mode", int'(mode), 2);

    press_mode();
    press_mode();
    h0 = cnt_h; m0 = cnt_m;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    repeat (5) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (4) @(negedge clk);
    chk("mode_inc_mode", int'(mode), 2);
    chk("mode_inc_no_pulse", (cnt_h - h0) + (cnt_m - m0), 0);

    press_mode();
    press_mode();
    btn_inc = 1'b1;
    repeat (4) @(negedge clk);
    issue_ticks(3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_mode", int'(mode), 0);
    h0 = cnt_h; m0 = cnt_m;
    issue_ticks(8);
    chk("rst_mid_no_pulse", (cnt_h - h0) + (cnt_m - m0), 0);
    chk("rst_mid_run", int'(mode), 0);
    btn_inc = 1'b0;
    repeat (4) @(negedge clk);

    auto_tick = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 14) == 0) btn_inc  = ~btn_inc;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    auto_tick = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
